instr_decode_stage: RTL
=======================

# instr_decode_stage

Registered, flow-controlled instruction decode stage for the CPU pipeline. It sits between fetch and register-read. It decodes the 32-bit instruction word into opcode, ALU/branch ops, constants and register indices, and registers the result with a valid/ready handshake and a one-entry skid buffer. It also flags load-use hazards against the previously emitted instruction and counts retired decodes. Constant widths, the opcode encodings it special-cases and the PC width are parametrised.

## Interface
- DATA_W, 32, width of sign/zero-extended constant outputs; legal range 32..64
- PC_W, 27, width of the PC tag carried alongside the instruction
- ARITHC_OP, 4'b0001, opcode whose A operand comes from instr[7:4] and whose B operand is forced to register 0
- LOAD_OP, 4'b1110, opcode treated as a load for hazard detection
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage can accept; equals !skid_valid && !reset
- in_instr  in  32  instruction word
- in_pc  in  PC_W  address of in_instr
- flush  in  1  discard all held and incoming instructions
- out_valid  out  1  decoded instruction held in the output register
- out_ready  in  1  downstream accepts
- out_pc  out  PC_W  PC of the held instruction
- out_instrOP, out_aluOP  out  4 each  instr[31:28] and instr[27:24]
- out_branchOP  out  3  instr[3:1]
- out_constAlu  out  DATA_W  instr[23:8], sign-extended
- out_const16  out  DATA_W  instr[27:12], sign-extended
- out_const16u  out  16  instr[27:12]
- out_const27  out  DATA_W  instr[27:1], zero-extended
- out_areg, out_breg, out_dreg  out  4 each  register indices
- out_he, out_oe, out_sig  out  1 each  instr[8], instr[0], instr[0]
- out_hazard  out  1  load-use hazard on the held instruction
- dec_count  out  32  number of output handshakes; wraps at 2^32

## Operation
- Decode is combinational on in_instr and is captured with the instruction. Register fields:
  - For ARITHC_OP: areg = instr[7:4], breg = 0.
  - Otherwise: areg = instr[11:8], breg = instr[7:4].
  - dreg = instr[3:0].
- Storage is the output register (OR) plus one skid register (SK). Each holds the full decoded bundle and a valid bit.
- Input accept: in_valid && in_ready.
  - If OR is empty, or OR is being consumed this cycle (out_valid && out_ready), the accepted word loads OR.
  - Otherwise it loads SK.
- Output consume (out_valid && out_ready) with SK valid: SK moves to OR and SK empties.
  - in_ready is low in that cycle, so no new word competes.
- Order is strictly FIFO. No instruction is dropped or duplicated except by flush.
- Hazard: a last-emitted register holds {was_load, dreg} of the most recent instruction to leave OR by handshake.
  - out_hazard is computed when a bundle enters OR.
  - It is 1 iff was_load is set, dreg != 0, and (areg == dreg, or breg == dreg with op != ARITHC_OP).
  - For an instruction entering OR behind another instruction still in OR, the comparison uses that predecessor.
- dec_count increments on each output handshake.
- flush takes priority over every other event in its cycle:
  - OR and SK valid are cleared and the input handshake in that cycle is ignored.
  - The last-emitted register is cleared.
  - dec_count is unaffected; an output handshake in the flush cycle still counts.

## Timing
- Latency is 1 cycle: an accept at edge N gives out_valid at N+1 when OR was empty.
- With out_ready held high, throughput is 1 instruction/cycle and SK stays empty.
- out_* fields are stable while out_valid && !out_ready.
- Reset values:
  - out_valid=0, SK valid=0, in_ready=0 during reset and 1 in the first cycle after.
  - All decoded outputs are 0, out_hazard=0, dec_count=0, last-emitted cleared.
- Reset asserted mid-operation has the same effect as flush and also zeroes dec_count.
- When full (OR and SK valid), in_ready=0. It returns to 1 in the cycle after the first consume.
- On flush, out_valid=0 in the next cycle and in_ready=1 in the next cycle.

## Test plan
- Decode: send 0x1ABC_D123 (ARITHC) -> out_areg=2, out_breg=0, out_dreg=3, out_constAlu=0xFFFF_BCD1, out_const16=0xFFFF_ABCD, out_const16u=0xABCD. Send 0x2000_0A51 -> areg=0xA, breg=5, oe=sig=1.
- Streaming: 8 back-to-back words with out_ready=1 -> out_valid from cycle 1, same order, dec_count=8, in_ready never low.
- Backpressure: out_ready=0 with 3 words offered -> 2 accepted, in_ready=0 from the second accept. Release out_ready -> words emerge in order and the third is accepted after the first consume.
- Hazard: LOAD_OP word with dreg=4 followed by a word with areg=4 -> out_hazard=1 on the second. Same pair with dreg=0 -> out_hazard=0.
- Flush: OR and SK full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed and offered words never appear.
- Reset mid-stream after dec_count=5 -> all outputs at reset values and dec_count=0.

Source files
------------

// File: rtl/instr_decode_stage.sv
// instr_decode_stage
// Registered instruction decode stage between fetch and register-read.
// The instruction word is decoded combinationally. The decoded bundle is
// held in an output register (OR), which is backed by a one-entry skid
// register (SK), with valid/ready handshakes on both sides. On entry to OR
// a load-use hazard flag is computed against the instruction emitted just
// before. The stage also counts output handshakes.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake; in_instr, in_pc are the payload
//   flush               drops held and incoming instructions
//   out_valid/out_ready downstream handshake
//   out_*               decoded fields of the instruction held in OR
//   out_hazard          load-use hazard flag of the instruction held in OR
//   dec_count           number of output handshakes (wraps at 2^32)
module instr_decode_stage #(
  parameter int         DATA_W    = 32,
  parameter int         PC_W      = 27,
  parameter logic [3:0] ARITHC_OP = 4'b0001,
  parameter logic [3:0] LOAD_OP   = 4'b1110
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [3:0]        out_instrOP,
  output logic [3:0]        out_aluOP,
  output logic [2:0]        out_branchOP,
  output logic [DATA_W-1:0] out_constAlu,
  output logic [DATA_W-1:0] out_const16,
  output logic [15:0]       out_const16u,
  output logic [DATA_W-1:0] out_const27,
  output logic [3:0]        out_areg,
  output logic [3:0]        out_breg,
  output logic [3:0]        out_dreg,
  output logic              out_he,
  output logic              out_oe,
  output logic              out_sig,
  output logic              out_hazard,
  output logic [31:0]       dec_count
);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [3:0]        instr_op;
    logic [3:0]        alu_op;
    logic [2:0]        branch_op;
    logic [DATA_W-1:0] const_alu;
    logic [DATA_W-1:0] const16;
    logic [15:0]       const16u;
    logic [DATA_W-1:0] const27;
    logic [3:0]        areg;
    logic [3:0]        breg;
    logic [3:0]        dreg;
    logic              he;
    logic              oe;
  } bundle_t;

  // Load-use check of bundle b against the instruction emitted before it.
  function automatic logic hazard_f(input bundle_t b, input logic prev_load,
                                    input logic [3:0] prev_dreg);
    return prev_load && (prev_dreg != 4'd0) &&
           ((b.areg == prev_dreg) ||
            ((b.breg == prev_dreg) && (b.instr_op != ARITHC_OP)));
  endfunction

  bundle_t     dec;
  bundle_t     or_q, or_d;
  bundle_t     sk_q, sk_d;
  logic        or_valid_q, or_valid_d;
  logic        sk_valid_q, sk_valid_d;
  logic        or_hazard_q, or_hazard_d;
  logic        last_load_q, last_load_d;
  logic [3:0]  last_dreg_q, last_dreg_d;
  logic [31:0] dec_count_q, dec_count_d;

  logic        in_fire;
  logic        out_fire;
  logic        prev_load;
  logic [3:0]  prev_dreg;

  // Combinational decode of the incoming word.
  always_comb begin
    dec           = '0;
    dec.pc        = in_pc;
    dec.instr_op  = in_instr[31:28];
    dec.alu_op    = in_instr[27:24];
    dec.branch_op = in_instr[3:1];
    dec.const_alu = {{(DATA_W-16){in_instr[23]}}, in_instr[23:8]};
    dec.const16   = {{(DATA_W-16){in_instr[27]}}, in_instr[27:12]};
    dec.const16u  = in_instr[27:12];
    dec.const27   = {{(DATA_W-27){1'b0}}, in_instr[27:1]};
    dec.dreg      = in_instr[3:0];
    dec.he        = in_instr[8];
    dec.oe        = in_instr[0];
    if (in_instr[31:28] == ARITHC_OP) begin
      dec.areg = in_instr[7:4];
      dec.breg = 4'd0;
    end else begin
      dec.areg = in_instr[11:8];
      dec.breg = in_instr[7:4];
    end
  end

  assign in_ready = !sk_valid_q && !reset;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = or_valid_q && out_ready;

  // Whatever enters OR this cycle follows the instruction leaving OR now,
  // if any; otherwise it follows the last one that already left.
  assign prev_load = out_fire ? (or_q.instr_op == LOAD_OP) : last_load_q;
  assign prev_dreg = out_fire ? or_q.dreg : last_dreg_q;

  always_comb begin
    or_d        = or_q;
    sk_d        = sk_q;
    or_valid_d  = or_valid_q;
    sk_valid_d  = sk_valid_q;
    or_hazard_d = or_hazard_q;
    last_load_d = last_load_q;
    last_dreg_d = last_dreg_q;
    dec_count_d = dec_count_q + {31'd0, out_fire};

    if (flush) begin
      or_valid_d  = 1'b0;
      sk_valid_d  = 1'b0;
      last_load_d = 1'b0;
      last_dreg_d = 4'd0;
    end else begin
      if (out_fire) begin
        last_load_d = (or_q.instr_op == LOAD_OP);
        last_dreg_d = or_q.dreg;
      end
      // in_ready is low while SK is valid, so SK refill and input accept
      // never happen in the same cycle.
      if (out_fire && sk_valid_q) begin
        or_d        = sk_q;
        or_hazard_d = hazard_f(sk_q, prev_load, prev_dreg);
        or_valid_d  = 1'b1;
        sk_valid_d  = 1'b0;
      end else if (in_fire && (!or_valid_q || out_fire)) begin
        or_d        = dec;
        or_hazard_d = hazard_f(dec, prev_load, prev_dreg);
        or_valid_d  = 1'b1;
      end else if (in_fire) begin
        sk_d       = dec;
        sk_valid_d = 1'b1;
      end else if (out_fire) begin
        or_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      or_q        <= '0;
      sk_q        <= '0;
      or_valid_q  <= 1'b0;
      sk_valid_q  <= 1'b0;
      or_hazard_q <= 1'b0;
      last_load_q <= 1'b0;
      last_dreg_q <= 4'd0;
      dec_count_q <= 32'd0;
    end else begin
      or_q        <= or_d;
      sk_q        <= sk_d;
      or_valid_q  <= or_valid_d;
      sk_valid_q  <= sk_valid_d;
      or_hazard_q <= or_hazard_d;
      last_load_q <= last_load_d;
      last_dreg_q <= last_dreg_d;
      dec_count_q <= dec_count_d;
    end
  end

  assign out_valid    = or_valid_q;
  assign out_pc       = or_q.pc;
  assign out_instrOP  = or_q.instr_op;
  assign out_aluOP    = or_q.alu_op;
  assign out_branchOP = or_q.branch_op;
  assign out_constAlu = or_q.const_alu;
  assign out_const16  = or_q.const16;
  assign out_const16u = or_q.const16u;
  assign out_const27  = or_q.const27;
  assign out_areg     = or_q.areg;
  assign out_breg     = or_q.breg;
  assign out_dreg     = or_q.dreg;
  assign out_he       = or_q.he;
  assign out_oe       = or_q.oe;
  assign out_sig      = or_q.oe;
  assign out_hazard   = or_hazard_q;
  assign dec_count    = dec_count_q;

endmodule
